// File: rtl/rr_sched_pkg.sv
// Shared widths and types for the round-robin PLM scheduler and its response path.
// The scheduling kernel and the response router both size their buses from these constants.
package rr_sched_pkg;

  localparam int ADDR_WIDTH  = 4;
  localparam int VALUE_WIDTH = 8;
  localparam int NCONSUMERS  = 2;
  localparam int NBANKS      = 1;
  localparam int NPORTS      = 2;
  localparam int NKERNELS    = NBANKS * NPORTS;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_WIDTH = id_width(NCONSUMERS);

  // One kernel request: {valid, we, addr, wdata}
  localparam int REQ_WIDTH       = 2 + ADDR_WIDTH + VALUE_WIDTH;
  localparam int PLM_INPUT_WIDTH = NKERNELS * REQ_WIDTH;

  typedef struct packed {
    logic                live;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_tag_delay_line.sv
// Ages one kernel's ownership tag by PLM_LATENCY cycles so it lines up with plm_rdata.
// Bubbles (live = 0) shift through like any other tag; reset empties every stage.
module rr_tag_delay_line #(
  parameter int  PLM_LATENCY = 1,
  parameter type tag_t       = rr_sched_pkg::tag_t
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [PLM_LATENCY];
  tag_t stage_d [PLM_LATENCY];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < PLM_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PLM_LATENCY; i++) begin
      if (reset) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[PLM_LATENCY-1];

endmodule

// File: rtl/rr_response_router.sv
// Steers returning PLM read words to the consumer that issued each read, one-cycle valid pulse.
// Lowest kernel wins a same-consumer collision; collisions and out-of-range ids set sticky err.
module rr_response_router #(
  parameter int  ADDR_WIDTH  = 4,
  parameter int  VALUE_WIDTH = 8,
  parameter int  NCONSUMERS  = 2,
  parameter int  NBANKS      = 1,
  parameter int  NPORTS      = 2,
  parameter int  PLM_LATENCY = 1,
  localparam int NKERNELS    = NBANKS * NPORTS,
  localparam int ID_WIDTH    = rr_sched_pkg::id_width(NCONSUMERS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NKERNELS-1:0]                   grant_valid,
  input  logic [NKERNELS-1:0]                   grant_we,
  input  logic [NKERNELS-1:0][ID_WIDTH-1:0]     grant_id,
  input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]  plm_rdata,
  output logic [NCONSUMERS-1:0]                 resp_valid,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data,
  output logic                                  err
);

  if (PLM_LATENCY < 1) begin : g_bad_latency
    $error("rr_response_router: PLM_LATENCY must be at least 1");
  end
  if (ADDR_WIDTH < 1) begin : g_bad_addr
    $error("rr_response_router: ADDR_WIDTH must be at least 1");
  end

  typedef struct packed {
    logic                live;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  tag_t [NKERNELS-1:0] tag_in;
  tag_t [NKERNELS-1:0] tag_aged;

  for (genvar k = 0; k < NKERNELS; k++) begin : g_kernel
    // Writes and idle slots enter as bubbles so they can never claim a consumer.
    assign tag_in[k].live = grant_valid[k] & ~grant_we[k];
    assign tag_in[k].id   = grant_id[k];

    rr_tag_delay_line #(
      .PLM_LATENCY (PLM_LATENCY),
      .tag_t       (tag_t)
    ) u_delay (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in[k]),
      .tag_out (tag_aged[k])
    );
  end

  logic [NCONSUMERS-1:0]                  resp_valid_q, resp_valid_d;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                                   err_q, err_d;
  logic [NCONSUMERS-1:0]                  claimed;

  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    claimed      = '0;
    // Ascending scan gives the lowest kernel index priority on a shared consumer.
    for (int k = 0; k < NKERNELS; k++) begin
      if (tag_aged[k].live) begin
        if (int'(tag_aged[k].id) >= NCONSUMERS) begin
          err_d = 1'b1;
        end else if (claimed[tag_aged[k].id]) begin
          err_d = 1'b1;
        end else begin
          claimed[tag_aged[k].id]      = 1'b1;
          resp_valid_d[tag_aged[k].id] = 1'b1;
          resp_data_d[tag_aged[k].id]  = plm_rdata[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rr_response_router.sv
// Directed bench for rr_response_router: one instance at PLM_LATENCY 1, one at PLM_LATENCY 3,
// driven from shared inputs; each scenario checks only the instance it targets.
module tb_rr_response_router;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      grant_valid;
  logic [1:0]      grant_we;
  logic [1:0][0:0] grant_id;
  logic [1:0][7:0] plm_rdata;

  logic [1:0]      l1_resp_valid, l3_resp_valid;
  logic [1:0][7:0] l1_resp_data,  l3_resp_data;
  logic            l1_err,        l3_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_response_router #(.PLM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .grant_valid(grant_valid), .grant_we(grant_we),
    .grant_id(grant_id), .plm_rdata(plm_rdata),
    .resp_valid(l1_resp_valid), .resp_data(l1_resp_data), .err(l1_err)
  );

  rr_response_router #(.PLM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .grant_valid(grant_valid), .grant_we(grant_we),
    .grant_id(grant_id), .plm_rdata(plm_rdata),
    .resp_valid(l3_resp_valid), .resp_data(l3_resp_data), .err(l3_err)
  );

  // Advance one cycle; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    grant_valid = '0;
    grant_we    = '0;
    grant_id    = '0;
    plm_rdata   = '0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    grant_valid = 2'b11;
    grant_we    = 2'b00;
    grant_id    = '0;
    plm_rdata   = {8'hFF, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({l1_resp_valid, l3_resp_valid} !== 4'b0000) begin
        bad++; $display("FAIL reset_valid cyc%0d: got %b/%b want 00/00", i, l1_resp_valid, l3_resp_valid);
      end
      total++;
      if ({l1_resp_data, l3_resp_data} !== 32'h0) begin
        bad++; $display("FAIL reset_data cyc%0d: got %h/%h want 0000/0000", i, l1_resp_data, l3_resp_data);
      end
      total++;
      if ({l1_err, l3_err} !== 2'b00) begin
        bad++; $display("FAIL reset_err cyc%0d: got %b%b want 00", i, l1_err, l3_err);
      end
    end
    reset = 1'b0;
    idle_inputs();
    step();
    total++;
    if ({l1_resp_valid, l3_resp_valid, l1_err, l3_err} !== 6'b0) begin
      bad++; $display("FAIL post_reset: got v=%b/%b err=%b%b want all 0",
                      l1_resp_valid, l3_resp_valid, l1_err, l3_err);
    end
  endtask

  task automatic test_single_read();
    grant_valid = 2'b01;
    grant_id[0] = 1'b1;
    step();
    idle_inputs();
    plm_rdata[0] = 8'hA5;
    step();
    total++;
    if (l1_resp_valid !== 2'b10) begin
      bad++; $display("FAIL single_valid: got %b want 10", l1_resp_valid);
    end
    total++;
    if (l1_resp_data[1] !== 8'hA5 || l1_resp_data[0] !== 8'h00) begin
      bad++; $display("FAIL single_data: got %h want a500", l1_resp_data);
    end
    plm_rdata = '0;
    step();
    total++;
    if (l1_resp_valid !== 2'b00 || l1_resp_data[1] !== 8'hA5) begin
      bad++; $display("FAIL single_hold: got v=%b d1=%h want v=00 d1=a5", l1_resp_valid, l1_resp_data[1]);
    end
    total++;
    if (l1_err !== 1'b0) begin
      bad++; $display("FAIL single_err: got %b want 0", l1_err);
    end
  endtask

  task automatic test_read_write();
    grant_valid = 2'b11;
    grant_we    = 2'b10;
    grant_id[0] = 1'b0;
    grant_id[1] = 1'b1;
    step();
    idle_inputs();
    plm_rdata[0] = 8'h3C;
    plm_rdata[1] = 8'hFF;
    step();
    total++;
    if (l1_resp_valid !== 2'b01) begin
      bad++; $display("FAIL rw_valid: got %b want 01", l1_resp_valid);
    end
    total++;
    if (l1_resp_data[0] !== 8'h3C || l1_resp_data[1] !== 8'hA5) begin
      bad++; $display("FAIL rw_data: got %h want a53c", l1_resp_data);
    end
    total++;
    if (l1_err !== 1'b0) begin
      bad++; $display("FAIL rw_err: got %b want 0", l1_err);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_collision();
    grant_valid = 2'b11;
    grant_id[0] = 1'b1;
    grant_id[1] = 1'b1;
    step();
    idle_inputs();
    plm_rdata[0] = 8'h11;
    plm_rdata[1] = 8'h22;
    step();
    total++;
    if (l1_resp_valid !== 2'b10) begin
      bad++; $display("FAIL coll_valid: got %b want 10", l1_resp_valid);
    end
    total++;
    if (l1_resp_data[1] !== 8'h11) begin
      bad++; $display("FAIL coll_data: got %h want 11", l1_resp_data[1]);
    end
    total++;
    if (l1_err !== 1'b1) begin
      bad++; $display("FAIL coll_err: got %b want 1", l1_err);
    end
    plm_rdata = '0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (l1_err !== 1'b1 || l1_resp_valid !== 2'b00) begin
      bad++; $display("FAIL coll_sticky: got err=%b v=%b want err=1 v=00", l1_err, l1_resp_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (l1_err !== 1'b0 || l3_err !== 1'b0) begin
      bad++; $display("FAIL coll_clear: got %b%b want 00", l1_err, l3_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_v;
    logic [7:0] exp_d;
    int         c;
    for (int i = 0; i < 8; i++) begin
      grant_valid  = (i < 4) ? 2'b10 : 2'b00;
      grant_id[1]  = 1'(i);
      plm_rdata[1] = (i >= 3 && i <= 6) ? 8'(i - 2) : 8'h00;
      step();
      if (i + 1 >= 4 && i + 1 <= 7) begin
        c     = (i + 1 - 4) % 2;
        exp_v = (c == 0) ? 2'b01 : 2'b10;
        exp_d = 8'(i + 1 - 3);
      end else begin
        c     = -1;
        exp_v = 2'b00;
        exp_d = 8'h00;
      end
      total++;
      if (l3_resp_valid !== exp_v) begin
        bad++; $display("FAIL stream_valid cyc%0d: got %b want %b", i + 1, l3_resp_valid, exp_v);
      end
      if (c >= 0) begin
        total++;
        if (l3_resp_data[c] !== exp_d) begin
          bad++; $display("FAIL stream_data cyc%0d c%0d: got %h want %h", i + 1, c, l3_resp_data[c], exp_d);
        end
      end
    end
    total++;
    if (l3_resp_data !== {8'h04, 8'h03} || l3_err !== 1'b0) begin
      bad++; $display("FAIL stream_final: got d=%h err=%b want 0403 err=0", l3_resp_data, l3_err);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    grant_valid = 2'b01;
    grant_id[0] = 1'b0;
    step();
    idle_inputs();
    reset = 1'b1;
    plm_rdata[0] = 8'h77;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (l3_resp_valid !== 2'b00) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midflight_valid: got %0d pulses want 0", seen);
    end
    total++;
    if (l3_resp_data !== 16'h0000 || l3_err !== 1'b0) begin
      bad++; $display("FAIL midflight_state: got d=%h err=%b want 0000 err=0", l3_resp_data, l3_err);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_read_write();
    test_collision();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_response_router.md
Name: rr_response_router

Overview:
- Return path of the round-robin PLM scheduler. The scheduling kernel forwards consumer requests to NKERNELS = NBANKS*NPORTS memory ports.
- This block records which consumer owns each issued read and delays that tag by the PLM read latency.
- It then steers each returning read word to the owning consumer, with a one-cycle valid pulse.
- It sits between the PLM read-data outputs and the consumers' response inputs.

Parameters:
- ADDR_WIDTH, 4, request address width (carried only for package width consistency).
- VALUE_WIDTH, 8, data word width.
- NCONSUMERS, 2, number of requesting consumers.
- NBANKS, 1, number of PLM banks.
- NPORTS, 2, ports per bank; NKERNELS = NBANKS*NPORTS.
- PLM_LATENCY, 1, cycles from grant issue to valid plm_rdata; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- grant_valid  input  [NKERNELS]  a request was issued on kernel k this cycle.
- grant_we  input  [NKERNELS]  the issued request is a write (no response is generated).
- grant_id  input  [NKERNELS] x $clog2(NCONSUMERS) (min 1)  consumer index owning the issued request.
- plm_rdata  input  [NKERNELS] x VALUE_WIDTH  PLM read data per kernel port.
- resp_valid  output  [NCONSUMERS]  one-cycle pulse: resp_data[c] is new.
- resp_data  output  [NCONSUMERS] x VALUE_WIDTH  last read word delivered to consumer c; held between pulses.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset values: resp_valid = 0, resp_data = 0, err = 0. Every delay-line stage becomes invalid.
- Reset asserted mid-operation drops all in-flight tags. No resp_valid is asserted in the cycle after reset or during reset.
- Tag capture: per kernel k, tag = {live, id}, where live = grant_valid[k] & ~grant_we[k]. The tag enters a PLM_LATENCY-deep shift register every cycle; invalid tags shift as bubbles.
- Capture condition: at cycle t+PLM_LATENCY, stage PLM_LATENCY-1 of kernel k holds the tag issued at t, and plm_rdata[k] is sampled in that same cycle.
- Delivery: on the next edge, resp_data[id] <= plm_rdata[k] and resp_valid[id] <= 1.
- Latency: grant at cycle t, resp_valid high in cycle t+PLM_LATENCY+1.
- Back-to-back grants on any kernel every cycle give a full-throughput response stream; there is no backpressure.
- resp_valid[c] is 0 in any cycle with no delivery to c. resp_data[c] keeps its last value.
- Collision: two or more kernels deliver to the same consumer in the same cycle.
  - The lowest kernel index wins; the other words are discarded.
  - err is set.
- Invalid id: a live tag with id >= NCONSUMERS (non-power-of-two NCONSUMERS) is discarded and sets err.
- err is sticky until reset.
- Writes (grant_we = 1) never produce a response and never set err.
- grant_id and grant_we are ignored when grant_valid = 0.

Decomposition:
- Package rr_sched_pkg holds:
  - NKERNELS and ID_WIDTH = max(1, $clog2(NCONSUMERS));
  - REQ_WIDTH and PLM_INPUT_WIDTH constants shared with the scheduling kernel;
  - a packed struct tag_t {logic live; logic [ID_WIDTH-1:0] id;}.
- Sub-module rr_tag_delay_line: one per kernel, with parameters PLM_LATENCY and tag_t. It is a synchronous-reset shift register that outputs the aged tag.
- The top level performs the priority demux, the response registers and err.

Test Plan:
- Reset check: assert reset for 2 cycles while grant_valid = all ones -> resp_valid = 0, resp_data = 0, err = 0 throughout and in the first post-reset cycle.
- Single read, PLM_LATENCY = 1:
  - stimulus: grant on kernel 0 with id = 1 at cycle t; plm_rdata[0] = 8'hA5 at t+1.
  - expected: resp_valid = 2'b10 at t+2, resp_data[1] = A5, resp_data[0] = 0.
- Parallel read plus write:
  - stimulus: kernel 0 reads for id 0, kernel 1 writes for id 1; rdata[0] = 8'h3C, rdata[1] = 8'hFF.
  - expected: only resp_valid[0] pulses, with data 3C; err = 0.
- Collision:
  - stimulus: both kernels read for id 1 in the same cycle; rdata = 8'h11 and 8'h22.
  - expected: resp_data[1] = 11, resp_valid = 2'b10, err = 1 and stays 1 until reset.
- Streaming with PLM_LATENCY = 3:
  - stimulus: kernel 1 issues reads on 4 consecutive cycles with id 0,1,0,1; rdata = 01,02,03,04.
  - expected: pulses on 4 consecutive cycles starting at t+4, with data routed 01→c0, 02→c1, 03→c0, 04→c1.
- Reset mid-flight (PLM_LATENCY = 3):
  - stimulus: issue a read, then assert reset 1 cycle later.
  - expected: no resp_valid is ever produced for that read.
